// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the fetch_out_t entry used by the output register and the skid buffer
package fetch_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } fetch_out_t;
  localparam fetch_out_t IDLE_OUT = '{pc: 32'h0, inst: NOP_INST, valid: 1'b0};
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: fetch bus; master=fetch (drives imem_req/addr, inst_code/pc/valid/misalign), slave=hazard/redirect/imem side
interface inst_fetch_if #(parameter int IMEM_AW = 9);
  logic               stall_i;
  logic               redirect_i;
  logic [31:0]        redirect_pc_i;
  logic               imem_req_o;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic [31:0]        imem_rdata_i;
  logic [31:0]        inst_code_o;
  logic [31:0]        pc_o;
  logic               valid_o;
  logic               misalign_o;
  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, inst_code_o, pc_o, valid_o, misalign_o
  );
  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, inst_code_o, pc_o, valid_o, misalign_o
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register (clk, rst_n, clear_i > load_i > drain_i, d_i in, q_o out with q_o.valid = occupied)
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic       drain_i,
  input  fetch_out_t d_i,
  output fetch_out_t q_o
);
  fetch_out_t entry_q, entry_d;
  always_comb entry_d = clear_i ? IDLE_OUT : load_i ? d_i : drain_i ? IDLE_OUT : entry_q;
  always_ff @(posedge clk) entry_q <= !rst_n ? IDLE_OUT : entry_d;
  assign q_o = entry_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC/issue, 1-cycle imem read, registered {inst,pc,valid} to decode with skid stall and redirect squash (clk, rst_n, bus master)
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 9
) (
  input logic          clk,
  input logic          rst_n,
  inst_fetch_if.master bus
);
  logic [31:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
  logic        inflight_q, inflight_d, misalign_q, misalign_d, issue, hold;
  fetch_out_t  out_q, out_d, skid, resp;
  always_comb begin
    issue         = rst_n & ~bus.stall_i & ~bus.redirect_i;
    hold          = bus.stall_i & out_q.valid;
    resp          = fetch_out_t'{pc: inflight_pc_q, inst: bus.imem_rdata_i, valid: 1'b1};
    pc_d          = bus.redirect_i ? {bus.redirect_pc_i[31:2], 2'b00} : issue ? pc_q + PC_STEP : pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
    misalign_d    = bus.redirect_i & |bus.redirect_pc_i[1:0];
    out_d         = bus.redirect_i ? fetch_out_t'{pc: out_q.pc, inst: NOP_INST, valid: 1'b0} :
                    hold           ? out_q :
                    skid.valid     ? skid :
                    inflight_q     ? resp :
                                     fetch_out_t'{pc: out_q.pc, inst: NOP_INST, valid: 1'b0};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      misalign_q    <= 1'b0;
      out_q         <= IDLE_OUT;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      misalign_q    <= misalign_d;
      out_q         <= out_d;
    end
  end
  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(bus.redirect_i),
    .load_i (~bus.redirect_i & hold & inflight_q),
    .drain_i(~bus.redirect_i & ~hold & skid.valid),
    .d_i    (resp),
    .q_o    (skid)
  );
  assign bus.imem_req_o  = issue;
  assign bus.imem_addr_o = pc_q[IMEM_AW+1:2];
  assign bus.inst_code_o = out_q.inst;
  assign bus.pc_o        = out_q.pc;
  assign bus.valid_o     = out_q.valid;
  assign bus.misalign_o  = misalign_q;
  assert property (@(posedge clk) disable iff (!rst_n) !(skid.valid && inflight_q));
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed stimulus with a cycle-level behavioural model of the fetch stream
module tb_inst_fetch;
  import fetch_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  inst_fetch_if #(.IMEM_AW(9)) bus ();
  inst_fetch #(.RESET_PC(32'h0), .IMEM_AW(9)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [31:0] mem [512];
  always @(posedge clk) bus.imem_rdata_i <= mem[bus.imem_addr_o];
  int passed = 0, total = 0;
  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0000 + {23'b0, pc[10:2]};
  endfunction
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
  endtask
  logic [31:0] m_pc = 0, m_fly_pc = 0, m_skid_pc = 0, m_out_pc = 0;
  bit m_fly = 0, m_skid = 0, m_out_v = 0, m_mis = 0, go = 0, iss, hld;
  always @(posedge clk) begin
    go <= 1'b1;
    if (!rst_n) begin
      m_pc = 0; m_fly = 0; m_skid = 0; m_out_v = 0; m_out_pc = 0; m_mis = 0;
    end else begin
      iss = !bus.stall_i && !bus.redirect_i;
      hld = bus.stall_i && m_out_v;
      if (bus.redirect_i) begin
        m_out_v = 0; m_skid = 0;
      end else if (hld) begin
        if (m_fly) begin m_skid = 1; m_skid_pc = m_fly_pc; end
      end else if (m_skid) begin
        m_out_v = 1; m_out_pc = m_skid_pc; m_skid = 0;
      end else if (m_fly) begin
        m_out_v = 1; m_out_pc = m_fly_pc;
      end else m_out_v = 0;
      m_fly = iss;
      if (iss) m_fly_pc = m_pc;
      m_pc = bus.redirect_i ? {bus.redirect_pc_i[31:2], 2'b00} : iss ? m_pc + 4 : m_pc;
      m_mis = bus.redirect_i && bus.redirect_pc_i[1:0] != 0;
    end
  end
  always @(negedge clk) if (go) begin
    check("valid", bus.valid_o, m_out_v);
    check("inst", bus.inst_code_o, m_out_v ? word_at(m_out_pc) : NOP_INST);
    check("pc", bus.pc_o, m_out_pc);
    check("req", bus.imem_req_o, rst_n && !bus.stall_i && !bus.redirect_i);
    if (bus.imem_req_o) check("addr", {23'b0, bus.imem_addr_o}, {23'b0, m_pc[10:2]});
    check("misalign", bus.misalign_o, m_mis);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic lit(input string n, input logic [31:0] pc, input logic [31:0] inst);
    check({n, "_valid"}, bus.valid_o, 1);
    check({n, "_pc"}, bus.pc_o, pc);
    check({n, "_inst"}, bus.inst_code_o, inst);
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 + i;
    rst_n = 0; bus.stall_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = 0;
    repeat (3) tick();
    check("rst_valid", bus.valid_o, 0);
    check("rst_inst", bus.inst_code_o, 32'h13);
    check("rst_addr", {23'b0, bus.imem_addr_o}, 0);
    rst_n = 1;
    tick(); check("boot_bubble", bus.valid_o, 0);
    tick(); lit("boot0", 32'h0, 32'h1000_0000);
    tick(); lit("boot4", 32'h4, 32'h1000_0001);
    tick(); lit("boot8", 32'h8, 32'h1000_0002);
    bus.stall_i = 1;
    tick(); tick();
    lit("stall_hold", 32'h8, 32'h1000_0002);
    check("stall_noreq", bus.imem_req_o, 0);
    tick(); bus.stall_i = 0;
    tick(); lit("release12", 32'hc, 32'h1000_0003);
    tick(); lit("release16", 32'h10, 32'h1000_0004);
    bus.redirect_i = 1; bus.redirect_pc_i = 32'h40;
    tick(); bus.redirect_i = 0; check("redir_t1", bus.valid_o, 0);
    tick(); check("redir_t2", bus.valid_o, 0);
    tick(); lit("redir_t3", 32'h40, 32'h1000_0010);
    tick(); lit("redir_t4", 32'h44, 32'h1000_0011);
    bus.stall_i = 1;
    tick(); tick(); lit("skid_hold", 32'h44, 32'h1000_0011);
    bus.redirect_i = 1; bus.redirect_pc_i = 32'h80;
    tick(); bus.redirect_i = 0; bus.stall_i = 0; check("skidredir_t1", bus.valid_o, 0);
    tick(); check("skidredir_t2", bus.valid_o, 0);
    tick(); lit("skidredir_t3", 32'h80, 32'h1000_0020);
    bus.redirect_i = 1; bus.redirect_pc_i = 32'h42;
    tick(); bus.redirect_i = 0; check("mis_t1", bus.misalign_o, 1);
    tick(); check("mis_t2", bus.misalign_o, 0);
    tick(); lit("mis_t3", 32'h40, 32'h1000_0010);
    bus.redirect_i = 1; bus.redirect_pc_i = 32'hffff_fffc;
    tick(); bus.redirect_i = 0;
    tick(); tick(); lit("wrap_top", 32'hffff_fffc, 32'h1000_01ff);
    tick(); lit("wrap_zero", 32'h0, 32'h1000_0000);
    bus.stall_i = 1;
    tick(); tick();
    rst_n = 0;
    tick(); check("midrst_valid", bus.valid_o, 0); check("midrst_inst", bus.inst_code_o, 32'h13);
    rst_n = 1; bus.stall_i = 0;
    tick(); check("midrst_bubble", bus.valid_o, 0);
    tick(); lit("midrst_pc0", 32'h0, 32'h1000_0000);
    tick(); lit("midrst_pc4", 32'h4, 32'h1000_0001);
    repeat (3) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
